lcd_window_overlay: RTL and testbench

Parametrised image-window compositor between the video timing generator and the LCD pins. It places a WIN_W×WIN_H frame-buffer image at a runtime-movable position, upscaled by 2^SCALE_SHIFT. It generates the frame-buffer read address with an incremental row accumulator (no multiplier) and expands RGB332 or RGB565 to RGB888 by bit replication. It delays hs/vs/de so they stay aligned with the RAM read latency, and fills pixels outside the window with a background colour.

---
 rtl/lcd_pkg.sv | 22 ++
 rtl/lcd_color_expand.sv | 23 ++
 rtl/lcd_window_overlay.sv | 189 ++++++++++++++++++
 tb/tb_lcd_window_overlay.sv | 261 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/lcd_pkg.sv
// Shared constants, pixel-format helpers and colour type for the LCD window compositor.
package lcd_pkg;

  localparam int PIX_FMT_RGB332 = 32'd0;
  localparam int PIX_FMT_RGB565 = 32'd1;

  typedef struct packed {
    logic [7:0] r;
    logic [7:0] g;
    logic [7:0] b;
  } rgb888_t;

  function automatic int pix_w(input int fmt);
    int w;
    case (fmt)
      PIX_FMT_RGB565: w = 32'd16;
      default:        w = 32'd8;
    endcase
    return w;
  endfunction

endpackage

// File: rtl/lcd_color_expand.sv
// Combinational RGB332/RGB565 to RGB888 expansion by bit replication (full scale maps to 8'hFF).
module lcd_color_expand
  import lcd_pkg::*;
#(
  parameter int PIX_FMT = PIX_FMT_RGB332
) (
  input  logic [pix_w(PIX_FMT)-1:0] pix,
  output rgb888_t                   rgb
);

  generate
    if (PIX_FMT == PIX_FMT_RGB565) begin : g_565
      assign rgb.r = {pix[15:11], pix[15:13]};
      assign rgb.g = {pix[10:5],  pix[10:9]};
      assign rgb.b = {pix[4:0],   pix[4:2]};
    end else begin : g_332
      assign rgb.r = {pix[7:5], pix[7:5], pix[7:6]};
      assign rgb.g = {pix[4:2], pix[4:2], pix[4:3]};
      assign rgb.b = {pix[1:0], pix[1:0], pix[1:0], pix[1:0]};
    end
  endgenerate

endmodule

// File: rtl/lcd_window_overlay.sv
// Places an upscaled frame-buffer window over the active video area; timing and colour
// leave together RAM_LAT+2 cycles after the generator's pre_* signals.
module lcd_window_overlay
  import lcd_pkg::*;
#(
  parameter int          WIN_W       = 128,
  parameter int          WIN_H       = 128,
  parameter int          SCALE_SHIFT = 1,
  parameter int          PIX_FMT     = PIX_FMT_RGB332,
  parameter int          ADDR_W      = 14,
  parameter int          RAM_LAT     = 1,
  parameter logic [23:0] BG_COLOR    = 24'h0F0F0F,
  parameter logic        VS_ACTIVE   = 1'b1
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      win_en,
  input  logic [11:0]               win_x0,
  input  logic [11:0]               win_y0,
  input  logic                      pre_hs,
  input  logic                      pre_vs,
  input  logic                      pre_de,
  input  logic [11:0]               active_x,
  input  logic [11:0]               active_y,
  output logic [ADDR_W-1:0]         ram_rd_addr,
  input  logic [pix_w(PIX_FMT)-1:0] ram_rd_data,
  output logic                      lcd_hs,
  output logic                      lcd_vs,
  output logic                      lcd_de,
  output logic [7:0]                lcd_r,
  output logic [7:0]                lcd_g,
  output logic [7:0]                lcd_b
);

  localparam int                SR_W     = (SCALE_SHIFT > 0) ? SCALE_SHIFT : 1;
  localparam logic [12:0]       X_LIM    = 13'(WIN_W << SCALE_SHIFT);
  localparam logic [12:0]       Y_LIM    = 13'(WIN_H << SCALE_SHIFT);
  localparam logic [SR_W-1:0]   SUB_MAX  = SR_W'((32'd1 << SCALE_SHIFT) - 32'd1);
  localparam logic [ADDR_W-1:0] ROW_STEP = ADDR_W'(WIN_W);
  localparam logic [ADDR_W-1:0] ROW_LAST = ADDR_W'((WIN_H - 1) * WIN_W);

  generate
    if (WIN_W * WIN_H > (32'd1 << ADDR_W)) begin : g_bad_addr_w
      $error("lcd_window_overlay: WIN_W*WIN_H does not fit in ADDR_W");
    end
    if (SCALE_SHIFT < 0 || SCALE_SHIFT > 2 || RAM_LAT < 1 || RAM_LAT > 2) begin : g_bad_param
      $error("lcd_window_overlay: SCALE_SHIFT or RAM_LAT out of range");
    end
  endgenerate

  typedef struct packed {
    logic in_win;
    logic hs;
    logic vs;
    logic de;
  } flags_t;

  logic              vs_prev_r;
  logic              de_prev_r;
  logic              frame_ok_r;
  logic              sh_en_r;
  logic [11:0]       sh_x0_r;
  logic [11:0]       sh_y0_r;
  logic [ADDR_W-1:0] row_base_r;
  logic [SR_W-1:0]   sub_row_r;
  logic              row_hit_r;
  logic              frame_start_s;
  logic              de_fall_s;
  logic [12:0]       dx_s;
  logic [12:0]       dy_s;
  logic [12:0]       col_s;
  logic              y_hit_s;
  logic              in_win_s;
  flags_t            pipe_r [RAM_LAT+1];
  flags_t            tail_s;
  rgb888_t           exp_s;
  rgb888_t           color_s;

  // Negative differences wrap to >= 4096, so they always fail the limit compare.
  assign dx_s          = {1'b0, active_x} - {1'b0, sh_x0_r};
  assign dy_s          = {1'b0, active_y} - {1'b0, sh_y0_r};
  assign col_s         = dx_s >> SCALE_SHIFT;
  assign y_hit_s       = (dy_s < Y_LIM);
  assign in_win_s      = frame_ok_r & sh_en_r & pre_de & (dx_s < X_LIM) & y_hit_s;
  assign frame_start_s = (pre_vs == VS_ACTIVE) && (vs_prev_r != VS_ACTIVE);
  assign de_fall_s     = de_prev_r & ~pre_de;

  // Frame-start shadowing and the incremental source-row base.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vs_prev_r  <= 1'b0;
      de_prev_r  <= 1'b0;
      frame_ok_r <= 1'b0;
      sh_en_r    <= 1'b0;
      sh_x0_r    <= 12'd0;
      sh_y0_r    <= 12'd0;
      row_base_r <= '0;
      sub_row_r  <= '0;
      row_hit_r  <= 1'b0;
    end else begin
      vs_prev_r <= pre_vs;
      de_prev_r <= pre_de;
      if (pre_de) begin
        row_hit_r <= y_hit_s;
      end
      if (frame_start_s) begin
        frame_ok_r <= 1'b1;
        sh_en_r    <= win_en;
        sh_x0_r    <= win_x0;
        sh_y0_r    <= win_y0;
        row_base_r <= '0;
        sub_row_r  <= '0;
      end else if (de_fall_s && row_hit_r) begin
        if (sub_row_r == SUB_MAX) begin
          sub_row_r <= '0;
          if (row_base_r != ROW_LAST) begin
            row_base_r <= row_base_r + ROW_STEP;
          end
        end else begin
          sub_row_r <= sub_row_r + SR_W'(1);
        end
      end
    end
  end

  // Read address, held between window pixels.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ram_rd_addr <= '0;
    end else if (in_win_s) begin
      ram_rd_addr <= row_base_r + ADDR_W'(col_s);
    end
  end

  // Flag/sync shift pipe matching the RAM read latency.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i <= RAM_LAT; i++) begin
        pipe_r[i] <= '0;
      end
    end else begin
      pipe_r[0] <= '{in_win: in_win_s, hs: pre_hs, vs: pre_vs, de: pre_de};
      for (int i = 1; i <= RAM_LAT; i++) begin
        pipe_r[i] <= pipe_r[i-1];
      end
    end
  end

  assign tail_s = pipe_r[RAM_LAT];

  lcd_color_expand #(
    .PIX_FMT (PIX_FMT)
  ) u_expand (
    .pix (ram_rd_data),
    .rgb (exp_s)
  );

  // Output colour select.
  always_comb begin
    color_s = '0;
    if (tail_s.in_win) begin
      color_s = exp_s;
    end else if (tail_s.de) begin
      color_s = BG_COLOR;
    end else begin
      color_s = '0;
    end
  end

  // Registered LCD outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lcd_hs <= 1'b0;
      lcd_vs <= 1'b0;
      lcd_de <= 1'b0;
      lcd_r  <= 8'd0;
      lcd_g  <= 8'd0;
      lcd_b  <= 8'd0;
    end else begin
      lcd_hs <= tail_s.hs;
      lcd_vs <= tail_s.vs;
      lcd_de <= tail_s.de;
      lcd_r  <= color_s.r;
      lcd_g  <= color_s.g;
      lcd_b  <= color_s.b;
    end
  end

endmodule

// File: tb/tb_lcd_window_overlay.sv
// Scoreboard bench: RGB332/RAM_LAT=1 and RGB565/RAM_LAT=2 instances driven by one timing stream.
module tb_lcd_window_overlay;

  localparam logic [23:0] BG = 24'h0F0F0F;

  typedef struct {
    string       tag;
    logic [26:0] val;
  } exp_t;

  typedef struct {
    int          fr;
    int          x;
    int          y;
    int          kind;
    logic [26:0] val;
    string       tag;
  } spec_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        rst_req;
  logic        win_en;
  logic [11:0] win_x0, win_y0, active_x, active_y;
  logic        pre_hs, pre_vs, pre_de;
  logic [13:0] addr1, addr2;
  logic [7:0]  rdata1;
  logic [15:0] rdata2, r2a;
  logic        hs1, vs1, de1, hs2, vs2, de2;
  logic [7:0]  r1, g1, b1, r2, g2, b2;

  exp_t  q_a[$];
  exp_t  q_l1[$];
  exp_t  q_l2[$];
  spec_t specs[$];

  int n_checks = 0;
  int n_errors = 0;
  int cur_frame = 0;

  logic        m_ok, m_en, m_prev_vs;
  int          m_x0, m_y0;
  logic [13:0] m_addr;

  always #5 clk = ~clk;

  lcd_window_overlay u_dut332 (
    .clk(clk), .rst_n(rst_n), .win_en(win_en), .win_x0(win_x0), .win_y0(win_y0),
    .pre_hs(pre_hs), .pre_vs(pre_vs), .pre_de(pre_de), .active_x(active_x), .active_y(active_y),
    .ram_rd_addr(addr1), .ram_rd_data(rdata1),
    .lcd_hs(hs1), .lcd_vs(vs1), .lcd_de(de1), .lcd_r(r1), .lcd_g(g1), .lcd_b(b1)
  );

  lcd_window_overlay #(.PIX_FMT(1), .RAM_LAT(2)) u_dut565 (
    .clk(clk), .rst_n(rst_n), .win_en(win_en), .win_x0(win_x0), .win_y0(win_y0),
    .pre_hs(pre_hs), .pre_vs(pre_vs), .pre_de(pre_de), .active_x(active_x), .active_y(active_y),
    .ram_rd_addr(addr2), .ram_rd_data(rdata2),
    .lcd_hs(hs2), .lcd_vs(vs2), .lcd_de(de2), .lcd_r(r2), .lcd_g(g2), .lcd_b(b2)
  );

  function automatic logic [15:0] ram565(input logic [13:0] a);
    logic [7:0] lo;
    lo = a[7:0];
    return (a == 14'd0) ? 16'hF800 : {lo, ~lo};
  endfunction

  function automatic logic [23:0] exp332(input logic [7:0] d);
    return {d[7:5], d[7:5], d[7:6], d[4:2], d[4:2], d[4:3], d[1:0], d[1:0], d[1:0], d[1:0]};
  endfunction

  function automatic logic [23:0] exp565(input logic [15:0] d);
    return {d[15:11], d[15:13], d[10:5], d[10:9], d[4:0], d[4:2]};
  endfunction

  // Frame-buffer models: contents are a function of the address.
  always @(posedge clk) rdata1 <= addr1[7:0];
  always @(posedge clk) begin
    r2a    <= ram565(addr2);
    rdata2 <= r2a;
  end

  task automatic check_eq(input string tag, input logic [26:0] got, input logic [26:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Pop expected values once each output has had its latency (addr 1, lcd332 3, lcd565 4).
  always @(negedge clk) begin
    exp_t e;
    if (q_a.size() > 1) begin
      e = q_a.pop_front();
      check_eq(e.tag, {13'd0, addr1}, e.val);
    end
    if (q_l1.size() > 3) begin
      e = q_l1.pop_front();
      check_eq(e.tag, {hs1, vs1, de1, r1, g1, b1}, e.val);
    end
    if (q_l2.size() > 4) begin
      e = q_l2.pop_front();
      check_eq(e.tag, {hs2, vs2, de2, r2, g2, b2}, e.val);
    end
  end

  task automatic add_spec(input int fr, input int x, input int y, input int kind,
                          input logic [26:0] val, input string tag);
    spec_t s;
    s.fr = fr; s.x = x; s.y = y; s.kind = kind; s.val = val; s.tag = tag;
    specs.push_back(s);
  endtask

  task automatic zero_queue_vals();
    exp_t t;
    foreach (q_a[i])  begin t = q_a[i];  t.val = 27'd0; q_a[i]  = t; end
    foreach (q_l1[i]) begin t = q_l1[i]; t.val = 27'd0; q_l1[i] = t; end
    foreach (q_l2[i]) begin t = q_l2[i]; t.val = 27'd0; q_l2[i] = t; end
  endtask

  // One pixel clock of stimulus plus the matching expected values.
  task automatic drive(input logic hs, input logic vs, input logic de, input int x, input int y);
    exp_t        ea, e1, e2;
    logic        inw;
    int          dx, dy;
    logic [13:0] ax;
    logic [23:0] c1, c2;
    @(posedge clk);
    #1;
    rst_n    = rst_req;
    pre_hs   = hs;
    pre_vs   = vs;
    pre_de   = de;
    active_x = 12'(x);
    active_y = 12'(y);
    if (!rst_req) begin
      m_ok = 1'b0; m_en = 1'b0; m_prev_vs = 1'b0; m_x0 = 0; m_y0 = 0; m_addr = 14'd0;
      zero_queue_vals();
      ea = '{"rst_addr", 27'd0};
      e1 = '{"rst_lcd332", 27'd0};
      e2 = '{"rst_lcd565", 27'd0};
    end else begin
      dx  = x - m_x0;
      dy  = y - m_y0;
      inw = m_ok && m_en && de && (dx >= 0) && (dx < 256) && (dy >= 0) && (dy < 256);
      ax  = 14'((dy / 2) * 128 + (dx / 2));
      if (inw) m_addr = ax;
      c1 = inw ? exp332(ax[7:0]) : (de ? BG : 24'h000000);
      c2 = inw ? exp565(ram565(ax)) : (de ? BG : 24'h000000);
      ea = '{"addr", {13'd0, m_addr}};
      e1 = '{"lcd332", {hs, vs, de, c1}};
      e2 = '{"lcd565", {hs, vs, de, c2}};
      foreach (specs[i]) begin
        if (de && specs[i].fr == cur_frame && specs[i].x == x && specs[i].y == y) begin
          case (specs[i].kind)
            0:       ea = '{specs[i].tag, specs[i].val};
            1:       e1 = '{specs[i].tag, {hs, vs, de, specs[i].val[23:0]}};
            default: e2 = '{specs[i].tag, {hs, vs, de, specs[i].val[23:0]}};
          endcase
        end
      end
      if (vs && !m_prev_vs) begin
        m_ok = 1'b1; m_en = win_en; m_x0 = int'(win_x0); m_y0 = int'(win_y0);
      end
      m_prev_vs = vs;
    end
    q_a.push_back(ea);
    q_l1.push_back(e1);
    q_l2.push_back(e2);
  endtask

  task automatic idle();
    drive(1'b0, 1'b0, 1'b0, 0, 0);
  endtask

  task automatic do_vs();
    idle();
    drive(1'b0, 1'b1, 1'b0, 0, 0);
    drive(1'b0, 1'b1, 1'b0, 0, 0);
    idle();
  endtask

  task automatic do_line(input int y, input bit full);
    int xs[8] = '{0, 3, 99, 100, 172, 192, 255, 256};
    if (full) begin
      for (int x = 0; x < 258; x++) drive(1'b0, 1'b0, 1'b1, x, y);
    end else begin
      foreach (xs[i]) drive(1'b0, 1'b0, 1'b1, xs[i], y);
    end
    idle();
    drive(1'b1, 1'b0, 1'b0, 0, 0);
    idle();
  endtask

  initial begin
    rst_n = 1'b1; rst_req = 1'b0;
    win_en = 1'b0; win_x0 = 12'd0; win_y0 = 12'd0;
    pre_hs = 1'b0; pre_vs = 1'b0; pre_de = 1'b0; active_x = 12'd0; active_y = 12'd0;
    m_ok = 1'b0; m_en = 1'b0; m_prev_vs = 1'b0; m_x0 = 0; m_y0 = 0; m_addr = 14'd0;
    #2 rst_n = 1'b0;

    add_spec(1, 3,   5,   0, 27'd257,      "addr_3_5");
    add_spec(1, 255, 255, 0, 27'd16383,    "addr_255_255");
    add_spec(1, 256, 0,   1, 27'h00F0F0F,  "bg_256_0");
    add_spec(1, 192, 2,   1, 27'h0FF0000,  "rgb332_e0");
    add_spec(1, 172, 0,   1, 27'h049B6AA,  "rgb332_56");
    add_spec(1, 0,   0,   2, 27'h0FF0000,  "rgb565_f800");
    add_spec(1, 100, 20,  0, 27'd1330,     "x0_change_ignored");
    add_spec(2, 100, 0,   0, 27'd0,        "moved_x100_addr0");
    add_spec(2, 99,  0,   1, 27'h00F0F0F,  "moved_x99_bg");
    add_spec(3, 3,   5,   1, 27'h00F0F0F,  "en0_bg");
    add_spec(3, 3,   8,   1, 27'h00F0F0F,  "en_mid_rise_bg");
    add_spec(4, 3,   52,  1, 27'h00F0F0F,  "after_rst_bg");
    add_spec(5, 0,   0,   0, 27'd0,        "next_frame_addr0");
    add_spec(5, 255, 0,   0, 27'd127,      "next_frame_addr127");

    repeat (4) idle();
    rst_req = 1'b1;
    repeat (3) idle();

    win_en = 1'b1; win_x0 = 12'd0; win_y0 = 12'd0;
    cur_frame = 1;
    do_vs();
    for (int y = 0; y < 260; y++) begin
      if (y == 10) win_x0 = 12'd100;
      do_line(y, y == 0);
    end

    cur_frame = 2;
    do_vs();
    for (int y = 0; y < 6; y++) begin
      if (y == 3) win_en = 1'b0;
      do_line(y, y == 0);
    end

    win_x0 = 12'd0;
    cur_frame = 3;
    do_vs();
    for (int y = 0; y < 11; y++) begin
      if (y == 6) win_en = 1'b1;
      do_line(y, 1'b0);
    end

    cur_frame = 4;
    do_vs();
    for (int y = 0; y < 61; y++) begin
      rst_req = (y != 50);
      do_line(y, 1'b0);
    end
    rst_req = 1'b1;

    cur_frame = 5;
    do_vs();
    for (int y = 0; y < 3; y++) do_line(y, y == 0);
    repeat (8) idle();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
